// File: rtl/usb_rx_packet_ctrl.sv
// rtl/usb_rx_packet_ctrl.sv - USB full-speed receive sequencer: SYNC hunt, PID check, byte framing, EOP status
module usb_rx_packet_ctrl #(
    parameter int MAX_BYTES = 1026,
    parameter int CNT_W     = 11
) (
    input  logic             useClk_i,
    input  logic             reset_i,
    input  logic             rxEnable_i,
    input  logic             checkData_i,
    input  logic [7:0]       parallelData_i,
    input  logic             bitStaff_i,
    input  logic             detectEop_i,
    output logic             oeTransmit_o,
    output logic             rxActive_o,
    output logic [7:0]       rxByte_o,
    output logic             rxValid_o,
    output logic [3:0]       rxPid_o,
    output logic             packetEnd_o,
    output logic             packetError_o,
    output logic [1:0]       errCode_o,
    output logic [CNT_W-1:0] byteCount_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_PID,
        S_DATA,
        S_DISCARD,
        S_EOPWAIT
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       SYNC_PAT = 8'h80;

    state_t           state_q, state_d;
    logic             bitEvt_q;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       rxByte_q, rxByte_d;
    logic             rxValid_q, rxValid_d;
    logic [3:0]       rxPid_q, rxPid_d;
    logic             packetEnd_q, packetEnd_d;
    logic             packetError_q, packetError_d;
    logic [1:0]       errCode_q, errCode_d;
    logic [CNT_W-1:0] byteCount_q, byteCount_d;

    logic validBit;
    logic byteDone;
    logic eopEvt;
    logic inPacket;

    // Data-side inputs lag checkData by one cycle, so every decision keys off the delayed strobe.
    assign validBit = bitEvt_q & bitStaff_i;
    assign byteDone = validBit & (bitCnt_q == 3'd7);
    assign eopEvt   = bitEvt_q & detectEop_i;
    assign inPacket = (state_q == S_PID) || (state_q == S_DATA) || (state_q == S_DISCARD);

    always_comb begin
        state_d       = state_q;
        bitCnt_d      = bitCnt_q;
        rxByte_d      = rxByte_q;
        rxValid_d     = 1'b0;
        rxPid_d       = rxPid_q;
        packetEnd_d   = 1'b0;
        packetError_d = 1'b0;
        errCode_d     = errCode_q;
        byteCount_d   = byteCount_q;

        if (!rxEnable_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_HUNT;
                S_HUNT: begin
                    if (bitEvt_q && (parallelData_i == SYNC_PAT)) begin
                        state_d     = S_PID;
                        bitCnt_d    = 3'd0;
                        errCode_d   = 2'd0;
                        byteCount_d = '0;
                    end
                end
                S_PID, S_DATA, S_DISCARD: begin
                    // EOP beats a byte completing on the same strobe.
                    if (eopEvt) begin
                        state_d     = S_EOPWAIT;
                        packetEnd_d = 1'b1;
                        if (errCode_q != 2'd0) begin
                            packetError_d = 1'b1;
                        end else if ((bitCnt_q != 3'd0) || (state_q == S_PID)) begin
                            packetError_d = 1'b1;
                            errCode_d     = 2'd2;
                        end
                    end else if (state_q != S_DISCARD) begin
                        if (validBit) begin
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                        if (byteDone && (state_q == S_PID)) begin
                            if (parallelData_i[3:0] == ~parallelData_i[7:4]) begin
                                rxByte_d    = parallelData_i;
                                rxValid_d   = 1'b1;
                                rxPid_d     = parallelData_i[3:0];
                                byteCount_d = CNT_ONE;
                                state_d     = S_DATA;
                            end else begin
                                errCode_d = 2'd1;
                                state_d   = S_DISCARD;
                            end
                        end else if (byteDone) begin
                            if (byteCount_q >= MAX_CNT) begin
                                errCode_d = 2'd3;
                                state_d   = S_DISCARD;
                            end else begin
                                rxByte_d    = parallelData_i;
                                rxValid_d   = 1'b1;
                                byteCount_d = byteCount_q + CNT_ONE;
                            end
                        end
                    end
                end
                S_EOPWAIT: begin
                    if (bitEvt_q && !detectEop_i) begin
                        state_d = S_HUNT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge useClk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            bitEvt_q      <= 1'b0;
            bitCnt_q      <= 3'd0;
            rxByte_q      <= 8'd0;
            rxValid_q     <= 1'b0;
            rxPid_q       <= 4'd0;
            packetEnd_q   <= 1'b0;
            packetError_q <= 1'b0;
            errCode_q     <= 2'd0;
            byteCount_q   <= '0;
        end else begin
            state_q       <= state_d;
            bitEvt_q      <= checkData_i;
            bitCnt_q      <= bitCnt_d;
            rxByte_q      <= rxByte_d;
            rxValid_q     <= rxValid_d;
            rxPid_q       <= rxPid_d;
            packetEnd_q   <= packetEnd_d;
            packetError_q <= packetError_d;
            errCode_q     <= errCode_d;
            byteCount_q   <= byteCount_d;
        end
    end

    assign oeTransmit_o  = inPacket;
    assign rxActive_o    = inPacket;
    assign rxByte_o      = rxByte_q;
    assign rxValid_o     = rxValid_q;
    assign rxPid_o       = rxPid_q;
    assign packetEnd_o   = packetEnd_q;
    assign packetError_o = packetError_q;
    assign errCode_o     = errCode_q;
    assign byteCount_o   = byteCount_q;

endmodule
